seq_det_ctrl: RTL and testbench
===============================

# seq_det_ctrl

Programmable serial sequence-detector controller. It holds a configurable pattern (length 1..PAT_W, overlapping or non-overlapping) and gates a serial bit stream with a valid/ready handshake. It raises a Mealy `hit` per match, counts matches, and stops in a HOLD state when a programmed match threshold is reached. It generalises the team's fixed-pattern Mealy detectors into one armed/disarmed resource that a host configures and sequences.

## Interface
- PAT_W, 8, maximum pattern length in bits.
- CNT_W, 8, width of the match counter and the threshold.
- LEN_W, $clog2(PAT_W)+1, width of `cfg_len` (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  configuration write strobe; honoured only in IDLE.
- cfg_pat  in  PAT_W  pattern. Bit `len-1` is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length. 0 is clamped to 1; values above PAT_W are clamped to PAT_W.
- cfg_ovl  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_thresh  in  CNT_W  match count that ends a run. 0 = run indefinitely.
- arm  in  1  start a run from IDLE, or restart a run from HOLD.
- disarm  in  1  abort to IDLE.
- x_valid  in  1  serial bit valid.
- x  in  1  serial bit.
- x_ready  out  1  bit accepted when `x_valid & x_ready` at a rising edge.
- hit  out  1  match pulse (see Configuration).
- hit_cnt  out  CNT_W  matches in the current run; saturates at all-ones.
- done  out  1  high in HOLD.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE:
  - `cfg_we` latches `pat`, `len` (after clamping), `ovl` and `thresh`.
  - `arm` goes to RUN and clears `hit_cnt`, the history and the fill count.
- RUN:
  - `x_ready=1`.
  - On each accepted bit, the history shifts left with `x` entering at bit 0.
  - The fill count increments, saturating at `len`.
- Match condition: RUN, accepted bit, `fill >= len-1` before the shift, and `{hist[len-2:0], x} == pat[len-1:0]`. For `len=1` the condition is `x == pat[0]`.
- On a match:
  - `hit_cnt` increments.
  - Overlap mode: the fill count is kept.
  - Non-overlap mode: the fill count is cleared to 0, so bits belonging to the matched pattern are never reused.
- Threshold: if `thresh != 0` and the incremented count equals `thresh`, the next state is HOLD.
- HOLD:
  - `x_ready=0`, `done=1`, `hit_cnt` frozen.
  - `arm` restarts a run exactly as `arm` does from IDLE.
  - `disarm` goes to IDLE.
- Priority: `disarm` > `arm` > bit acceptance.
  - `arm` in RUN is ignored.
  - `cfg_we` outside IDLE is ignored.
  - `disarm` in the same cycle as a matching bit: the bit is not accepted and no hit occurs.
- `disarm` keeps `hit_cnt` for readback; the next `arm` clears it.
- Leading fill: no match is possible until `len` bits have been accepted since arm or since the last non-overlap hit. Reset zeros in the history never match.

## Timing
- Reset values:
  - state IDLE; `x_ready=0`, `busy=0`, `done=0`, `hit=0`, `hit_cnt=0`.
  - `pat=0`, `len=1`, `ovl=0`, `thresh=0`; history 0, fill 0.
- `x_ready`, `busy` and `done` are decoded from the state register only (no input paths).
- `arm` takes effect at the next edge; `x_ready` goes high the cycle after `arm` is sampled.
- HOLD is entered on the edge that accepts the threshold-reaching bit; `done` is high the cycle after that bit.
- Reset asserted mid-run returns everything to reset values immediately; any in-flight `hit` drops.

## Configuration
- SEQ_DET_HIT_REG_EN undefined: `hit` is combinational (Mealy) and high in the same cycle as the accepted matching bit.
- SEQ_DET_HIT_REG_EN defined:
  - `hit` is a flop, high for one cycle, one cycle after the accepted matching bit.
  - It is cleared by reset and by `disarm`.
  - `hit_cnt` timing is unchanged.

## Structure
- Package `seq_det_pkg`: state enum `{IDLE, RUN, HOLD}` and the `LEN_W` width function.
- Sub-module `seq_det_matcher` contains the history shift register, the fill counter and the length-masked compare.
  - Inputs: `shift_en`, `clr`, `x`, `pat`, `len`, `ovl`.
  - Output: `match`.
- The controller FSM, configuration registers and counter stay in `seq_det_ctrl`.

## Test plan
- Overlap: `pat=101`, `len=3`, `ovl=1`, `thresh=0`; stream 1,0,1,0,1 → `hit` on the 3rd and 5th bits; `hit_cnt=2`.
- Non-overlap: same stream with `ovl=0` → `hit` on the 3rd bit only; `hit_cnt=1`.
- Threshold: `thresh=2`, `ovl=1`, stream 1,0,1,0,1,0,1 → HOLD after the 5th bit; `done=1`; `x_ready=0`; the 6th and 7th bits are not accepted; `hit_cnt` stays 2.
- Fill guard: `pat=000`, `len=3`, arm, stream 0,0,0 → no `hit` on bits 1–2, `hit` on bit 3. A stall (`x_valid=0`) for 4 cycles between bits changes nothing.
- Priority and reset:
  - `disarm` together with a matching 3rd bit → no `hit`; state IDLE; `hit_cnt` unchanged.
  - `cfg_we` in RUN is ignored.
  - `rst` low mid-RUN → all outputs at reset values.
- Configuration and clamping: `len=0` with `pat[0]=1`, stream 1,1 → two hits. Repeat the overlap case with SEQ_DET_HIT_REG_EN defined → each `hit` is one cycle later.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types for the programmable sequence detector.
//   - state_t   : controller state encoding (IDLE, RUN, HOLD)
//   - len_width : width of the pattern-length field for a given PAT_W
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Enough bits to hold the value PAT_W itself (lengths run 1..PAT_W).
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_det_matcher.sv
// seq_det_matcher
//   History shift register, fill counter and length-masked pattern compare.
//   Ports:
//     clk, rst  : clock, asynchronous active-low reset
//     shift_en  : an accepted bit is presented this cycle
//     clr       : clear history and fill count (start of a run)
//     x         : serial bit
//     pat, len  : latched pattern and clamped length (1..PAT_W)
//     ovl       : 1 = overlapping detection
//     match     : combinational, high when the accepted bit completes the pattern
module seq_det_matcher
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             x,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic             ovl,
    output logic             match
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic             fill_ok;

    // Candidate window: the history as it will look after this bit shifts in.
    assign cand = {hist[PAT_W-2:0], x};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // len is never 0 here, so len-1 cannot wrap. The fill guard is what keeps
    // reset zeros in the history from ever matching an all-zero pattern.
    assign fill_ok = (fill >= (len - LEN_W'(1)));
    assign match   = shift_en && fill_ok && ((cand & mask) == (pat & mask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= cand;
            if (match && !ovl) begin
                fill <= '0;
            end else if (fill < len) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
//   Armed/disarmed serial sequence-detector controller.
//   Ports:
//     clk, rst          : clock, asynchronous active-low reset
//     cfg_we            : configuration write (IDLE only)
//     cfg_pat/len/ovl/thresh : pattern, length, overlap mode, match threshold
//     arm, disarm       : start/restart a run, abort to IDLE (disarm wins)
//     x_valid, x        : serial bit input
//     x_ready           : bit acceptance (high in RUN)
//     hit               : match pulse
//     hit_cnt           : matches in the current run, saturating
//     done, busy        : HOLD / RUN indicators
//     state_dbg         : current controller state
//   Build option SEQ_DET_HIT_REG_EN: when defined, hit is registered and
//   appears one cycle after the matching bit; otherwise it is combinational.
//
//   Handshake: a bit transfers on a rising edge where x_valid && x_ready and
//   disarm is low; x_ready depends only on the state register, x_valid may
//   assert at any time and the source must hold x until the transfer.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             arm,
    input  logic             disarm,
    input  logic             x_valid,
    input  logic             x,
    output logic             x_ready,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             done,
    output logic             busy,
    output state_t           state_dbg
);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] thresh_q;
    logic [LEN_W-1:0] len_clamped;
    logic [CNT_W-1:0] cnt_inc;
    logic             shift_en;
    logic             restart;
    logic             match;

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            len_clamped = LEN_W'(PAT_W);
        end
    end

    // disarm blocks both the bit and the restart in the same cycle.
    assign shift_en = (state == RUN) && x_valid && !disarm;
    assign restart  = (state != RUN) && arm && !disarm;
    assign cnt_inc  = (&hit_cnt) ? hit_cnt : hit_cnt + CNT_W'(1);

    seq_det_matcher #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (restart),
        .x        (x),
        .pat      (pat_q),
        .len      (len_q),
        .ovl      (ovl_q),
        .match    (match)
    );

`ifdef SEQ_DET_HIT_REG_EN
    logic hit_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pat_q    <= '0;
            len_q    <= LEN_W'(1);
            ovl_q    <= 1'b0;
            thresh_q <= '0;
            hit_cnt  <= '0;
`ifdef SEQ_DET_HIT_REG_EN
            hit_q    <= 1'b0;
`endif
        end else begin
`ifdef SEQ_DET_HIT_REG_EN
            hit_q <= match && !disarm;
`endif
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pat_q    <= cfg_pat;
                        len_q    <= len_clamped;
                        ovl_q    <= cfg_ovl;
                        thresh_q <= cfg_thresh;
                    end
                    if (restart) begin
                        state   <= RUN;
                        hit_cnt <= '0;
                    end
                end
                RUN: begin
                    if (disarm) begin
                        state <= IDLE;
                    end else if (match) begin
                        hit_cnt <= cnt_inc;
                        if ((thresh_q != '0) && (cnt_inc == thresh_q)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (disarm) begin
                        state <= IDLE;
                    end else if (restart) begin
                        state   <= RUN;
                        hit_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_DET_HIT_REG_EN
    assign hit = hit_q;
`else
    assign hit = match;
`endif

    assign x_ready   = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == HOLD);
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl
//   Directed and random stimulus for seq_det_ctrl with an expected-hit queue.
module tb_seq_det_ctrl;
  import seq_det_pkg::*;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = len_width(PAT_W);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic [CNT_W-1:0] cfg_thresh;
  logic             arm;
  logic             disarm;
  logic             x_valid;
  logic             x;
  logic             x_ready;
  logic             hit;
  logic [CNT_W-1:0] hit_cnt;
  logic             done;
  logic             busy;
  state_t           state_dbg;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_pat    (cfg_pat),
    .cfg_len    (cfg_len),
    .cfg_ovl    (cfg_ovl),
    .cfg_thresh (cfg_thresh),
    .arm        (arm),
    .disarm     (disarm),
    .x_valid    (x_valid),
    .x          (x),
    .x_ready    (x_ready),
    .hit        (hit),
    .hit_cnt    (hit_cnt),
    .done       (done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         vectors = 0;
  int         miscompares = 0;
  logic [0:0] exp_q[$];
  logic       hq[$];
`ifdef SEQ_DET_HIT_REG_EN
  logic       pend = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: inputs are already driven; check hit mid-cycle, then
  // advance to the next falling edge.
  task automatic tick();
    logic e;
    logic now_exp;
    #1;
    e = 1'b0;
    if (x_valid && x_ready && !disarm && rst) begin
      check("accept_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
      end
    end
`ifdef SEQ_DET_HIT_REG_EN
    now_exp = pend;
    pend = e;
`else
    now_exp = e;
`endif
    check("hit", 32'(hit), 32'(now_exp));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic b, input logic acc, input logic h);
    x_valid = 1'b1;
    x = b;
    check("x_ready", 32'(x_ready), 32'(acc));
    if (acc) exp_q.push_back(h);
    tick();
    x_valid = 1'b0;
    x = 1'b0;
  endtask

  task automatic configure(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic o, input logic [CNT_W-1:0] t);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_thresh = t;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_after_arm", 32'(busy), 32'd1);
    check("x_ready_after_arm", 32'(x_ready), 32'd1);
    check("cnt_after_arm", 32'(hit_cnt), 32'd0);
    hq.delete();
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    check("state_after_disarm", 32'(state_dbg), 32'(IDLE));
    check("busy_after_disarm", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_ready"}, 32'(x_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_hit"}, 32'(hit), 32'd0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  // Reference: keep the accepted bits since the last clear and compare the
  // newest len of them against the pattern, MSB of the pattern first.
  function automatic logic model_bit(input logic b, input logic [PAT_W-1:0] p,
                                     input int l, input logic o);
    logic h;
    hq.push_back(b);
    if (hq.size() > 16) void'(hq.pop_front());
    h = 1'b0;
    if (hq.size() >= l) begin
      h = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (hq[hq.size() - l + i] !== p[l-1-i]) h = 1'b0;
      end
    end
    if (h && !o) hq.delete();
    return h;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [PAT_W-1:0] pv;
    logic             h;
    logic             b;
    logic             o;
    int               exp_cnt;

    rst = 1'b0; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    cfg_thresh = '0; arm = 1'b0; disarm = 1'b0; x_valid = 1'b0; x = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Overlap: 101 over 1,0,1,0,1
    configure(8'b101, 4'd3, 1'b1, 8'd0);
    do_arm();
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 1); send(0, 1, 0); send(1, 1, 1);
    check("ovl_cnt", 32'(hit_cnt), 32'd2);
    do_disarm();

    // Non-overlap: same stream
    configure(8'b101, 4'd3, 1'b0, 8'd0);
    do_arm();
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 1); send(0, 1, 0); send(1, 1, 0);
    check("novl_cnt", 32'(hit_cnt), 32'd1);
    do_disarm();

    // Threshold 2 -> HOLD after 5th bit, 6th/7th refused
    configure(8'b101, 4'd3, 1'b1, 8'd2);
    do_arm();
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 1); send(0, 1, 0); send(1, 1, 1);
    check("thr_done", 32'(done), 32'd1);
    check("thr_busy", 32'(busy), 32'd0);
    check("thr_state", 32'(state_dbg), 32'(HOLD));
    send(0, 0, 0); send(1, 0, 0);
    check("thr_cnt", 32'(hit_cnt), 32'd2);
    do_arm();                                   // restart from HOLD
    check("thr_restart_done", 32'(done), 32'd0);
    do_disarm();

    // Fill guard: 000 with stalls between bits
    configure(8'b000, 4'd3, 1'b1, 8'd0);
    do_arm();
    send(0, 1, 0); idle(4); send(0, 1, 0); idle(4); send(0, 1, 1);
    check("fill_cnt", 32'(hit_cnt), 32'd1);
    do_disarm();

    // cfg_we and arm in RUN ignored; disarm beats a matching bit
    configure(8'b101, 4'd3, 1'b1, 8'd0);
    do_arm();
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 1);
    cfg_we = 1'b1; cfg_pat = 8'b0; cfg_len = 4'd1; arm = 1'b1;
    tick();
    cfg_we = 1'b0; arm = 1'b0;
    check("run_arm_cnt_kept", 32'(hit_cnt), 32'd1);
    check("run_arm_busy", 32'(busy), 32'd1);
    send(0, 1, 0); send(1, 1, 1);
    check("run_cfg_ignored_cnt", 32'(hit_cnt), 32'd2);
    send(0, 1, 0);
    x_valid = 1'b1; x = 1'b1; disarm = 1'b1;  // would match 101
    tick();
    x_valid = 1'b0; x = 1'b0; disarm = 1'b0;
    check("prio_state", 32'(state_dbg), 32'(IDLE));
    check("prio_cnt", 32'(hit_cnt), 32'd2);

    // Reset mid-run with a matching bit on the input
    do_arm();
    send(1, 1, 0); send(0, 1, 0); send(1, 1, 1); send(0, 1, 0);
    x_valid = 1'b1; x = 1'b1; rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
`ifdef SEQ_DET_HIT_REG_EN
    pend = 1'b0;
`endif
    @(negedge clk);
    x_valid = 1'b0; x = 1'b0; rst = 1'b1;
    tick();
    // Configuration back at reset values: pat=0, len=1
    do_arm();
    send(0, 1, 1); send(1, 1, 0);
    check("rstcfg_cnt", 32'(hit_cnt), 32'd1);
    do_disarm();

    // len=0 clamps to 1
    configure(8'h01, 4'd0, 1'b0, 8'd0);
    do_arm();
    send(1, 1, 1); send(1, 1, 1);
    check("len0_cnt", 32'(hit_cnt), 32'd2);
    do_disarm();

    // len=15 clamps to 8: 0xA5 MSB first
    configure(8'hA5, 4'd15, 1'b1, 8'd0);
    do_arm();
    pv = 8'hA5;
    for (int i = PAT_W - 1; i >= 0; i--) send(pv[i], 1, (i == 0));
    check("len15_cnt", 32'(hit_cnt), 32'd1);
    do_disarm();

    // Counter saturation
    configure(8'h01, 4'd1, 1'b1, 8'd0);
    do_arm();
    for (int i = 0; i < 260; i++) send(1, 1, 1);
    check("sat_cnt", 32'(hit_cnt), 32'd255);
    do_disarm();

    // Random streams against the reference, both modes
    pv = 8'b1101;
    for (int r = 0; r < 2; r++) begin
      o = r[0];
      configure(pv, 4'd4, o, 8'd0);
      do_arm();
      exp_cnt = 0;
      for (int i = 0; i < 60; i++) begin
        b = 1'($urandom_range(0, 1));
        h = model_bit(b, pv, 4, o);
        if (h) exp_cnt++;
        send(b, 1, h);
        idle($urandom_range(0, 2));
      end
      check("rand_cnt", 32'(hit_cnt), 32'(exp_cnt));
      do_disarm();
    end

    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
